mux_rr_sched: RTL

//   Round-robin scheduler that shares the 4:1 bit mux between four requesters.

---
 rtl/mux_arb_pkg.sv | 16 +
 rtl/mux_rr_sched_rr_pick4.sv | 28 ++
 rtl/mux_rr_sched.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin scheduler of the 4:1 bit mux.
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot2(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux_rr_sched_rr_pick4.sv
// Combinational round-robin picker: first set req bit scanning ptr, ptr+1, ... mod 4.
module rr_pick4 import mux_arb_pkg::*; (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [SEL_W-1:0]   off;

    // Rotate so that rot[0] is the requester at ptr.
    assign dbl = {req, req};
    assign rot = dbl[ptr +: N_REQ];

    always_comb begin
        off = 2'd0;
        if (rot[0])      off = 2'd0;
        else if (rot[1]) off = 2'd1;
        else if (rot[2]) off = 2'd2;
        else if (rot[3]) off = 2'd3;
    end

    assign any = |req;
    assign idx = ptr + off;

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler sharing a 4:1 bit mux; registers the selected bit with its requester id.
// Optional mux output checker enabled by defining MUX_FAULT_CHECK_EN.
module mux_rr_sched import mux_arb_pkg::*; #(
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             mux_out,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] grant,
    output logic             out_valid,
    output logic             out_bit,
    output logic [SEL_W-1:0] out_id
`ifdef MUX_FAULT_CHECK_EN
    ,
    input  logic [N_REQ-1:0] data_ref,
    input  logic             fault_clr,
    output logic             fault_ind
`endif
);

    localparam int HC_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    state_t           state, state_nxt;
    logic [SEL_W-1:0] ptr, ptr_nxt;
    logic [HC_W-1:0]  hold_cnt, hold_nxt;
    logic [SEL_W-1:0] sel_nxt;
    logic [N_REQ-1:0] grant_nxt;
    logic             valid_nxt, bit_nxt;
    logic [SEL_W-1:0] id_nxt;
    logic             sample, release_g;
    logic [SEL_W-1:0] pick_ptr, pick_idx;
    logic             pick_any;

    // While granted, the picker only matters on release, where the rotation restarts after the owner.
    assign pick_ptr = (state == S_GRANT) ? sel + 2'd1 : ptr;
    assign sample   = (state == S_GRANT) && grant[sel] && req[sel];

    rr_pick4 u_pick (
        .req (req),
        .ptr (pick_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        hold_nxt  = hold_cnt;
        sel_nxt   = sel;
        grant_nxt = grant;
        valid_nxt = 1'b0;
        bit_nxt   = out_bit;
        id_nxt    = out_id;
        release_g = 1'b0;
        case (state)
            S_IDLE: begin
                if (pick_any) begin
                    state_nxt = S_GRANT;
                    grant_nxt = onehot2(pick_idx);
                    sel_nxt   = pick_idx;
                    hold_nxt  = '0;
                end
            end
            S_GRANT: begin
                if (sample) begin
                    valid_nxt = 1'b1;
                    bit_nxt   = mux_out;
                    id_nxt    = sel;
                    hold_nxt  = hold_cnt + 1'b1;
                end
                release_g = !req[sel] || (sample && hold_cnt == HC_W'(MAX_HOLD - 1));
                if (release_g) begin
                    ptr_nxt  = sel + 2'd1;
                    hold_nxt = '0;
                    if (pick_any) begin
                        grant_nxt = onehot2(pick_idx);
                        sel_nxt   = pick_idx;
                    end else begin
                        state_nxt = S_IDLE;
                        grant_nxt = '0;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            sel       <= '0;
            grant     <= '0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_id    <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_nxt;
            sel       <= sel_nxt;
            grant     <= grant_nxt;
            out_valid <= valid_nxt;
            out_bit   <= bit_nxt;
            out_id    <= id_nxt;
        end
    end

`ifdef MUX_FAULT_CHECK_EN
    // Sticky mismatch flag; a new mismatch outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_ind <= 1'b0;
        end else if (sample && (mux_out != data_ref[sel])) begin
            fault_ind <= 1'b1;
        end else if (fault_clr) begin
            fault_ind <= 1'b0;
        end
    end
`endif

endmodule
